// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and helpers for the RGB color monitor.
//   color_e     - decoded color index (RED..MAGENTA = 0..5, OFF = 7)
//   state_e     - monitor FSM states
//   NUM_COLORS  - number of colors in the cycling sequence
//   rgb_decode  - {r,g,b} pattern -> color_e
//   next_color  - successor of a color in the RED..MAGENTA ring
package rgb_pkg;

  typedef enum logic [2:0] {
    RED     = 3'd0,
    GREEN   = 3'd1,
    BLUE    = 3'd2,
    YELLOW  = 3'd3,
    CYAN    = 3'd4,
    MAGENTA = 3'd5,
    OFF     = 3'd7
  } color_e;

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_RUN    = 1'b1
  } state_e;

  localparam int NUM_COLORS = 6;

  // Pattern bits are ordered {r, g, b}.
  function automatic color_e rgb_decode(input logic [2:0] rgb);
    color_e c;
    case (rgb)
      3'b100:  c = RED;
      3'b010:  c = GREEN;
      3'b001:  c = BLUE;
      3'b110:  c = YELLOW;
      3'b011:  c = CYAN;
      3'b101:  c = MAGENTA;
      default: c = OFF;
    endcase
    return c;
  endfunction

  function automatic color_e next_color(input color_e c);
    color_e n;
    case (c)
      RED:     n = GREEN;
      GREEN:   n = BLUE;
      BLUE:    n = YELLOW;
      YELLOW:  n = CYAN;
      CYAN:    n = MAGENTA;
      MAGENTA: n = RED;
      default: n = OFF;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/rgb_color_monitor_sync_filter.sv
// rgb_sync_filter: two-flop synchronizer per RGB line followed by a
// stability filter.
//   clk, rst_n   - clock, synchronous active-low reset
//   rgb_in[2:0]  - asynchronous {r,g,b} lines
//   stable_pat   - last pattern that was held STABLE_CYCLES samples
//   stable_stb   - one-cycle pulse when stable_pat takes a new value
//                  (also on the very first accepted pattern)
module rgb_sync_filter
  import rgb_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] rgb_in,
  output logic [2:0] stable_pat,
  output logic       stable_stb
);

  // STABLE_CYCLES <= 255, so the saturating count never exceeds 254.
  localparam int              CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pat_q, pat_d;
  logic             vld_q, vld_d;
  logic             stb_q, stb_d;

  always_comb begin
    sync1_d = rgb_in;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    vld_d   = vld_q;
    stb_d   = 1'b0;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    // Register the accepted pattern; this extra stage keeps the pin-to-event
    // latency at STABLE_CYCLES+3. The strobe only fires on a real change so
    // the FSM can treat it as "new pattern accepted".
    if ((cnt_q == CNT_MAX) && (!vld_q || (cand_q != pat_q))) begin
      pat_d = cand_q;
      vld_d = 1'b1;
      stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      vld_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      vld_q   <= vld_d;
      stb_q   <= stb_d;
    end
  end

  assign stable_pat = pat_q;
  assign stable_stb = stb_q;

endmodule

// File: rtl/rgb_color_monitor.sv
// rgb_color_monitor: filters and decodes the RGB LED lines and emits one
// event per accepted color change (ended color, its dwell in cycles).
//   clk, rst_n           - clock, synchronous active-low reset
//   rgb_r/g/b            - asynchronous LED lines
//   evt_valid/evt_ready  - single-entry output handshake
//   evt_color            - color of the interval that just ended
//   evt_dwell            - its dwell time, saturating at 2^DWELL_W-1
//   evt_seq_err          - transition broke the RED..MAGENTA ring order
//   evt_overflow         - sticky: an event was dropped (cleared by reset)
// Optional feature macro: RGB_MONITOR_SEQ_CHECK_EN enables evt_seq_err.
module rgb_color_monitor
  import rgb_pkg::*;
#(
  parameter int STABLE_CYCLES = 16,
  parameter int DWELL_W       = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rgb_r,
  input  logic               rgb_g,
  input  logic               rgb_b,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [2:0]         evt_color,
  output logic [DWELL_W-1:0] evt_dwell,
  output logic               evt_seq_err,
  output logic               evt_overflow
);

  logic [2:0] stable_pat;
  logic       stable_stb;

  rgb_sync_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .rgb_in    ({rgb_r, rgb_g, rgb_b}),
    .stable_pat(stable_pat),
    .stable_stb(stable_stb)
  );

  color_e code;
  assign code = rgb_decode(stable_pat);

  state_e             state_q, state_d;
  color_e             acc_q, acc_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] dwell_inc;
  logic               ev_fire;
  logic               ev_seq_err;

  assign dwell_inc = (dwell_q == {DWELL_W{1'b1}}) ? dwell_q : dwell_q + 1'b1;

`ifdef RGB_MONITOR_SEQ_CHECK_EN
  // Only ring colors take part; anything touching OFF never flags.
  assign ev_seq_err = (acc_q != OFF) && (code != OFF) && (code != next_color(acc_q));
`else
  assign ev_seq_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    dwell_d = dwell_q;
    ev_fire = 1'b0;
    case (state_q)
      S_SETTLE: begin
        if (stable_stb) begin
          acc_d   = code;
          dwell_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Different patterns can share a code (000/111), hence the compare.
        if (stable_stb && (code != acc_q)) begin
          ev_fire = 1'b1;
          acc_d   = code;
          dwell_d = '0;
        end else begin
          dwell_d = dwell_inc;
        end
      end
      default: state_d = S_SETTLE;
    endcase
  end

  logic               evt_valid_q, evt_valid_d;
  logic [2:0]         evt_color_q, evt_color_d;
  logic [DWELL_W-1:0] evt_dwell_q, evt_dwell_d;
  logic               evt_seq_err_q, evt_seq_err_d;
  logic               evt_overflow_q, evt_overflow_d;

  always_comb begin
    evt_valid_d    = evt_valid_q;
    evt_color_d    = evt_color_q;
    evt_dwell_d    = evt_dwell_q;
    evt_seq_err_d  = evt_seq_err_q;
    evt_overflow_d = evt_overflow_q;

    if (ev_fire && (!evt_valid_q || evt_ready)) begin
      evt_valid_d   = 1'b1;
      evt_color_d   = acc_q;
      evt_dwell_d   = dwell_inc;   // includes the current cycle
      evt_seq_err_d = ev_seq_err;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end

    if (ev_fire && evt_valid_q && !evt_ready) begin
      evt_overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_SETTLE;
      acc_q          <= RED;
      dwell_q        <= '0;
      evt_valid_q    <= 1'b0;
      evt_color_q    <= '0;
      evt_dwell_q    <= '0;
      evt_seq_err_q  <= 1'b0;
      evt_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      dwell_q        <= dwell_d;
      evt_valid_q    <= evt_valid_d;
      evt_color_q    <= evt_color_d;
      evt_dwell_q    <= evt_dwell_d;
      evt_seq_err_q  <= evt_seq_err_d;
      evt_overflow_q <= evt_overflow_d;
    end
  end

  assign evt_valid    = evt_valid_q;
  assign evt_color    = evt_color_q;
  assign evt_dwell    = evt_dwell_q;
  assign evt_seq_err  = evt_seq_err_q;
  assign evt_overflow = evt_overflow_q;

endmodule
